// File: rtl/rotation_sync_if.sv
// Signal bundle between the rotation timing stage and its consumers:
// the raw hall input plus the slice/revolution timing outputs.
interface rotation_sync_if #(
  parameter int unsigned SLICE_BITS = 6,
  parameter int unsigned CNT_W      = 24
);
  logic                  hall;
  logic                  cycle_marker;
  logic [SLICE_BITS-1:0] slice_index;
  logic                  slice_strobe;
  logic                  rev_strobe;
  logic [CNT_W-1:0]      period;

  // Timing stage side: consumes hall, produces timing
  modport master (
    input  hall,
    output cycle_marker,
    output slice_index,
    output slice_strobe,
    output rev_strobe,
    output period
  );

  // Sensor/consumer side
  modport slave (
    output hall,
    input  cycle_marker,
    input  slice_index,
    input  slice_strobe,
    input  rev_strobe,
    input  period
  );
endinterface

// File: rtl/rotation_sync.sv
// Revolution timing for the rotating LED display: synchronises the hall
// pulse, measures the revolution period, splits each revolution into
// 2^SLICE_BITS angular slices and flags when rotation is locked.
module rotation_sync #(
  parameter int unsigned SLICE_BITS = 6,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MIN_PERIOD = 1024,
  parameter int unsigned MAX_PERIOD = 32'h00FF_FFFF
) (
  input  logic           clock,
  input  logic           reset,
  rotation_sync_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  localparam logic [CNT_W:0]        MIN_W      = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]        MAX_W      = (CNT_W+1)'(MAX_PERIOD);
  localparam logic [SLICE_BITS-1:0] LAST_SLICE = '1;

  // Synchroniser and edge detector
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic edge_det;

  // Control
  state_t state_q, state_d;
  logic   edge_ok;
  logic   timeout;

  // Period measurement
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W:0]   cnt_inc;

  // Slice timing and registered outputs
  logic [CNT_W-1:0]      slice_len_q,    slice_len_d;
  logic [CNT_W-1:0]      slice_cnt_q,    slice_cnt_d;
  logic [SLICE_BITS-1:0] slice_index_q,  slice_index_d;
  logic                  slice_strobe_q, slice_strobe_d;
  logic                  rev_strobe_q,   rev_strobe_d;
  logic [CNT_W-1:0]      period_q,       period_d;
  logic                  cycle_marker_q, cycle_marker_d;

  // Next values of the hall synchroniser chain
  always_comb begin
    sync1_d = bus.hall;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign edge_det = sync2_q & ~prev_q;
  assign cnt_inc  = {1'b0, period_cnt_q} + (CNT_W+1)'(1);

  // Glitch lockout applies only once a reference edge exists; an accepted
  // edge always beats a coincident timeout.
  assign edge_ok = edge_det & ((state_q == ST_IDLE) | (cnt_inc >= MIN_W));
  assign timeout = (state_q != ST_IDLE) & (cnt_inc >= MAX_W) & ~edge_ok;

  // Period counter: clear on accepted edge, else count and saturate at MAX-1
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (edge_ok) begin
      period_cnt_d = '0;
    end else if (cnt_inc < MAX_W) begin
      period_cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  // Lock state machine: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (edge_ok) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (edge_ok)      state_d = ST_LOCKED;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_LOCKED: begin
        if (timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Period capture, slice stepping and output values
  always_comb begin
    period_d       = period_q;
    slice_len_d    = slice_len_q;
    slice_cnt_d    = slice_cnt_q;
    slice_index_d  = slice_index_q;
    slice_strobe_d = 1'b0;
    rev_strobe_d   = 1'b0;
    cycle_marker_d = (state_d == ST_LOCKED);

    if (edge_ok && (state_q != ST_IDLE)) begin
      period_d       = cnt_inc[CNT_W-1:0];
      slice_len_d    = CNT_W'(cnt_inc >> SLICE_BITS);
      slice_index_d  = '0;
      slice_cnt_d    = '0;
      slice_strobe_d = 1'b1;
      rev_strobe_d   = 1'b1;
    end else if (timeout) begin
      slice_index_d  = '0;
      slice_cnt_d    = '0;
    end else if (state_q == ST_LOCKED) begin
      // The last slice never wraps: it absorbs the division remainder and
      // any slow-down until the next sensor edge restarts slice 0.
      if ((slice_cnt_q == slice_len_q - CNT_W'(1)) && (slice_index_q != LAST_SLICE)) begin
        slice_index_d  = slice_index_q + SLICE_BITS'(1);
        slice_cnt_d    = '0;
        slice_strobe_d = 1'b1;
      end else if (slice_index_q != LAST_SLICE) begin
        slice_cnt_d    = slice_cnt_q + CNT_W'(1);
      end
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      state_q        <= ST_IDLE;
      period_cnt_q   <= '0;
      slice_len_q    <= '0;
      slice_cnt_q    <= '0;
      slice_index_q  <= '0;
      slice_strobe_q <= 1'b0;
      rev_strobe_q   <= 1'b0;
      period_q       <= '0;
      cycle_marker_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      state_q        <= state_d;
      period_cnt_q   <= period_cnt_d;
      slice_len_q    <= slice_len_d;
      slice_cnt_q    <= slice_cnt_d;
      slice_index_q  <= slice_index_d;
      slice_strobe_q <= slice_strobe_d;
      rev_strobe_q   <= rev_strobe_d;
      period_q       <= period_d;
      cycle_marker_q <= cycle_marker_d;
    end
  end

  assign bus.cycle_marker = cycle_marker_q;
  assign bus.slice_index  = slice_index_q;
  assign bus.slice_strobe = slice_strobe_q;
  assign bus.rev_strobe   = rev_strobe_q;
  assign bus.period       = period_q;

endmodule

// File: tb/tb_rotation_sync.sv
// Bench for rotation_sync: randomized hall pulse trains checked every cycle
// against a timestamp-based model, plus literal expectations per scenario.
module tb_rotation_sync;

  localparam int SB   = 6;
  localparam int CW   = 24;
  localparam int MINP = 1024;
  localparam int MAXP = 20000;

  logic clock = 1'b0;
  logic reset;

  rotation_sync_if #(.SLICE_BITS(SB), .CNT_W(CW)) bus ();

  rotation_sync #(
    .SLICE_BITS(SB),
    .CNT_W(CW),
    .MIN_PERIOD(MINP),
    .MAX_PERIOD(MAXP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  longint      k       = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, k);
    end
  endtask

  // Model: accepted edges are timestamped by clock count; slice position is
  // derived from time since the last locked edge.
  bit     s1, s2, pv, det;
  bit     active, locked;
  longint k_last, k_lock, gap, t, n;
  longint e_period, L;
  bit     e_marker, e_sstb, e_rstb;
  longint e_index;

  always @(posedge clock) begin
    k++;
    if (reset) begin
      s1 = 0; s2 = 0; pv = 0;
      active = 0; locked = 0;
      k_last = k; k_lock = k;
      e_period = 0; L = 1;
    end else begin
      det = s2 & ~pv;
      pv = s2; s2 = s1; s1 = bus.hall;
      gap = k - k_last;
      if (det && (!active || gap >= MINP)) begin
        if (active) begin
          e_period = (gap > MAXP) ? MAXP : gap;
          L        = e_period >> SB;
          locked   = 1;
          k_lock   = k;
        end
        active = 1;
        k_last = k;
      end else if (active && gap >= MAXP) begin
        active = 0;
        locked = 0;
      end
    end
    if (locked) begin
      t        = k - k_lock;
      n        = t / L;
      e_index  = (n > 63) ? 63 : n;
      e_sstb   = ((t % L) == 0) && (n <= 63);
      e_rstb   = (t == 0);
      e_marker = 1;
    end else begin
      e_index = 0; e_sstb = 0; e_rstb = 0; e_marker = 0;
    end
  end

  always @(negedge clock) begin
    if (k > 0) begin
      chk("cycle_marker", bus.cycle_marker, e_marker);
      chk("slice_index",  bus.slice_index,  e_index);
      chk("slice_strobe", bus.slice_strobe, e_sstb);
      chk("rev_strobe",   bus.rev_strobe,   e_rstb);
      chk("period",       bus.period,       e_period);
    end
  end

  int unsigned sstb_cnt = 0;
  int unsigned rstb_cnt = 0;
  always @(posedge clock) begin
    if (bus.slice_strobe === 1'b1) sstb_cnt++;
    if (bus.rev_strobe === 1'b1)   rstb_cnt++;
  end

  // Hall pulse rising now, next rise exactly gap cycles later
  task automatic rev(input int gap);
    int w;
    w = $urandom_range(1, 6);
    bus.hall = 1'b1;
    repeat (w) @(negedge clock);
    bus.hall = 1'b0;
    repeat (gap - w) @(negedge clock);
  endtask

  task automatic rev_glitch(input int gap, input int at);
    int w, gw;
    w  = $urandom_range(1, 6);
    gw = $urandom_range(1, 3);
    bus.hall = 1'b1;
    repeat (w) @(negedge clock);
    bus.hall = 1'b0;
    repeat (at - w) @(negedge clock);
    bus.hall = 1'b1;
    repeat (gw) @(negedge clock);
    bus.hall = 1'b0;
    repeat (gap - at - gw) @(negedge clock);
  endtask

  task automatic rev_chk(input string tag, input int gap, input int exp_slices,
                         input int exp_index, input int exp_period);
    int unsigned c0, r0;
    c0 = sstb_cnt;
    r0 = rstb_cnt;
    rev(gap);
    chk({tag, "_slices"}, sstb_cnt - c0, exp_slices);
    chk({tag, "_revs"},   rstb_cnt - r0, 1);
    chk({tag, "_index"},  bus.slice_index, exp_index);
    chk({tag, "_period"}, bus.period, exp_period);
  endtask

  initial begin
    int unsigned c0, r0;
    reset    = 1'b1;
    bus.hall = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_marker", bus.cycle_marker, 0);
    chk("rst_index",  bus.slice_index,  0);
    chk("rst_period", bus.period,       0);
    chk("rst_sstb",   bus.slice_strobe, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);

    // First pulse: acquire only
    rev(6400);
    chk("acq_marker", bus.cycle_marker, 0);
    chk("acq_period", bus.period,       0);

    // Second pulse: lock, strobes three edges after hall is sampled high
    c0 = sstb_cnt;
    r0 = rstb_cnt;
    bus.hall = 1'b1;
    @(negedge clock); chk("lat1_marker", bus.cycle_marker, 0);
    @(negedge clock); chk("lat2_marker", bus.cycle_marker, 0);
    chk("lat2_rev", bus.rev_strobe, 0);
    @(negedge clock);
    chk("lock_marker", bus.cycle_marker, 1);
    chk("lock_rev",    bus.rev_strobe,   1);
    chk("lock_sstb",   bus.slice_strobe, 1);
    chk("lock_period", bus.period,       6400);
    chk("lock_index",  bus.slice_index,  0);
    bus.hall = 1'b0;
    repeat (6400 - 3) @(negedge clock);
    chk("rev1_slices", sstb_cnt - c0, 64);
    chk("rev1_revs",   rstb_cnt - r0, 1);
    chk("rev1_index",  bus.slice_index, 63);

    // Glitch inside a 6400 revolution is ignored
    c0 = sstb_cnt;
    r0 = rstb_cnt;
    rev_glitch(6400, $urandom_range(300, 900));
    chk("glitch_slices", sstb_cnt - c0, 64);
    chk("glitch_revs",   rstb_cnt - r0, 1);
    chk("glitch_index",  bus.slice_index, 63);
    chk("glitch_period", bus.period, 6400);

    // Speed-up to 5120 (edge lands in slice 51), then slow-downs
    rev_chk("speedup", 5120, 52, 51, 6400);
    rev_chk("l80",     6400, 64, 63, 5120);
    rev_chk("slow",    8000, 64, 63, 6400);
    rev_chk("l125",    6400, 52, 51, 8000);

    // Last pulse then stall: timeout 20000 cycles after the accepted edge
    bus.hall = 1'b1;
    repeat (2) @(negedge clock);
    bus.hall = 1'b0;
    repeat (20000) @(negedge clock);
    chk("prestall_marker", bus.cycle_marker, 1);
    @(negedge clock);
    chk("stall_marker", bus.cycle_marker, 0);
    chk("stall_index",  bus.slice_index,  0);
    chk("stall_period", bus.period,       6400);
    repeat (5) @(negedge clock);

    // Relock needs two pulses
    bus.hall = 1'b1;
    repeat (3) @(negedge clock);
    chk("relock1_marker", bus.cycle_marker, 0);
    bus.hall = 1'b0;
    repeat (6400 - 3) @(negedge clock);
    bus.hall = 1'b1;
    repeat (3) @(negedge clock);
    chk("relock2_marker", bus.cycle_marker, 1);
    bus.hall = 1'b0;
    repeat (3000) @(negedge clock);
    chk("slice30_index", bus.slice_index, 30);

    // Reset at slice 30 with a coincident hall pulse
    reset    = 1'b1;
    bus.hall = 1'b1;
    @(negedge clock);
    chk("midrst_marker", bus.cycle_marker, 0);
    chk("midrst_index",  bus.slice_index,  0);
    chk("midrst_period", bus.period,       0);
    chk("midrst_sstb",   bus.slice_strobe, 0);
    reset    = 1'b0;
    bus.hall = 1'b0;
    repeat (10) @(negedge clock);
    chk("postrst_marker", bus.cycle_marker, 0);
    chk("postrst_index",  bus.slice_index,  0);

    // Random pulse train straddling the lockout threshold
    for (int i = 0; i < 8; i++) rev($urandom_range(200, 2000));
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rotation_sync.md
# rotation_sync

Upstream timing stage for the rotating 16x16 LED display. Takes the raw once-per-revolution hall-sensor pulse and measures the revolution period. Divides each revolution into 2^SLICE_BITS equal angular slices, emitting the slice index and per-slice strobe the frame source needs to pick which 16x16 image to show. Also drives `cycle_marker`, the display-enable consumed by the matrix driver: it is high only while rotation is locked.

## Interface
- SLICE_BITS, 6, log2 of slices per revolution (64 slices)
- CNT_W, 24, width of period counter and `period` output
- MIN_PERIOD, 1024, minimum accepted edge spacing in cycles (glitch lockout); must be >= 2^SLICE_BITS
- MAX_PERIOD, 2^24-1, edge spacing at or above which rotation is declared stalled; must be > MIN_PERIOD
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- hall  in  1  raw sensor pulse, asynchronous to `clock`, active-high
- cycle_marker  out  1  high while LOCKED, low otherwise
- slice_index  out  SLICE_BITS  current angular slice, 0 at sensor edge
- slice_strobe  out  1  one-cycle pulse on every slice start, including slice 0
- rev_strobe  out  1  one-cycle pulse on every accepted edge in LOCKED
- period  out  CNT_W  last measured revolution length in cycles

## Operation
- `hall` passes through a 2-flop synchronizer, then a rising-edge detector (`sync2 & ~prev`).
- `period_cnt`: cleared to 0 in the cycle an edge is accepted; otherwise increments, saturating at MAX_PERIOD-1.
- Edge acceptance:
  - IDLE: every detected edge is accepted.
  - ACQUIRE and LOCKED: an edge is accepted only if `period_cnt+1 >= MIN_PERIOD`; other edges are ignored and have no effect on any state.
- On an accepted edge outside IDLE: `period <= period_cnt+1`; `slice_len <= (period_cnt+1) >> SLICE_BITS` (floor).
- States:
  - IDLE: reset state; all outputs low/zero. Accepted edge -> ACQUIRE.
  - ACQUIRE: measuring the first period; outputs stay low/zero. Accepted edge -> LOCKED; load period and slice_len; slice_index=0, slice_cnt=0; pulse slice_strobe and rev_strobe.
  - LOCKED: cycle_marker=1.
    - Accepted edge: reload period and slice_len, slice_index=0, slice_cnt=0, pulse both strobes.
    - Otherwise, if slice_cnt == slice_len-1 and slice_index < 2^SLICE_BITS-1: slice_index+1, slice_cnt=0, pulse slice_strobe.
    - Otherwise, if slice_index is at the last slice: hold index and slice_cnt; no wrap, no strobe.
    - Otherwise: slice_cnt+1.
- Timeout: in ACQUIRE or LOCKED, when `period_cnt+1 >= MAX_PERIOD` -> IDLE next cycle. Clear slice_index, strobes and cycle_marker; `period` keeps its last value.
- An accepted edge in the same cycle as a slice rollover takes priority (index -> 0).
- An accepted edge in the same cycle as timeout takes priority (edge handled, no timeout).

## Timing
- Reset values: cycle_marker=0, slice_index=0, slice_strobe=0, rev_strobe=0, period=0; state IDLE; internal counters and sync flops 0.
- Reset asserted mid-revolution forces reset values on the next clock regardless of `hall`.
- Latency: strobes for an accepted edge assert exactly 3 clock edges after the first edge at which `hall` is sampled high (2 sync + 1 output register).
- All outputs are registered; strobes are exactly one cycle wide.
- In steady state with period P and L = P >> SLICE_BITS: slice k starts k*L cycles after slice 0.
- The last slice absorbs the remainder P - 64*L (for SLICE_BITS=6).
- First cycle_marker rise comes at the second accepted edge after reset or timeout.

## Test plan
- **Lock-up:** reset, then `hall` pulses every 6400 cycles -> cycle_marker rises at the 2nd pulse (+3 cycles); period=6400; slice_strobe every 100 cycles; slice_index 0..63; rev_strobe once per revolution.
- **Glitch lockout:** while locked at 6400, inject an extra hall pulse 500 cycles after an edge -> no change to slice_index, period or strobes; next real edge accepted normally.
- **Speed-up:** period drops to 5120 -> the edge arrives during slice 51 or later; index jumps to 0 with a strobe; the following revolution has L=80, slices every 80 cycles.
- **Slow-down:** period rises to 8000 with L still 100 -> index holds at 63 with no extra strobes until the edge. The next revolution uses L=125.
- **Stall:** stop `hall` with MAX_PERIOD=20000 -> state goes IDLE; cycle_marker=0 and slice_index=0 20000 cycles after the last edge; period holds 6400. Resuming needs two pulses to relock.
- **Reset mid-operation:** assert reset for 1 cycle while locked at slice 30 -> all outputs zero next cycle; a hall edge coincident with reset is ignored.
